systolic_gemm_ctrl: RTL and testbench

Sequencer for the weight-stationary-free GEMM systolic array in the GPT-2 ASIC datapath.
- Per job, it pulses the array's global accumulator clear.
- It reads K activation vectors and K weight vectors from the operand buffers and applies the diagonal input skew (row r delayed r cycles, column c delayed c cycles).
- It waits out the array drain, then reports completion with a start/busy/done handshake.
- It sits between the layer scheduler and the systolic array.

---
 rtl/systolic_gemm_ctrl_if.sv | 41 ++++
 rtl/systolic_gemm_ctrl.sv | 147 ++++++++++++++
 tb/tb_systolic_gemm_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_gemm_ctrl_if.sv
// Job handshake, operand-buffer read port and skewed array feed of systolic_gemm_ctrl.
// master: the sequencer; slave: the scheduler / buffers / array around it.
interface systolic_gemm_ctrl_if #(
  parameter int PE_ROWS      = 4,
  parameter int PE_COLS      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int K_W          = 8
);
  logic                            start;
  logic [K_W-1:0]                  k_len;
  logic                            abort;
  logic                            feed_stall;
  logic                            busy;
  logic                            done;
  logic                            rd_en;
  logic [K_W-1:0]                  rd_addr;
  logic [PE_ROWS*DATA_WIDTH-1:0]   act_rd_data;
  logic [PE_COLS*WEIGHT_WIDTH-1:0] wgt_rd_data;
  logic                            clear_accum;
  logic [PE_ROWS*DATA_WIDTH-1:0]   act_out;
  logic [PE_ROWS-1:0]              act_valid_out;
  logic [PE_COLS*WEIGHT_WIDTH-1:0] wgt_out;
  logic [PE_COLS-1:0]              wgt_valid_out;
  logic [31:0]                     perf_cycles;
  logic [31:0]                     perf_stalls;

  modport master (
    input  start, k_len, abort, feed_stall, act_rd_data, wgt_rd_data,
    output busy, done, rd_en, rd_addr, clear_accum,
           act_out, act_valid_out, wgt_out, wgt_valid_out,
           perf_cycles, perf_stalls
  );

  modport slave (
    output start, k_len, abort, feed_stall, act_rd_data, wgt_rd_data,
    input  busy, done, rd_en, rd_addr, clear_accum,
           act_out, act_valid_out, wgt_out, wgt_valid_out,
           perf_cycles, perf_stalls
  );
endinterface

// File: rtl/systolic_gemm_ctrl.sv
// GEMM systolic-array sequencer: clear, K operand reads with diagonal skew, drain, done.
// Optional job performance counters are built when GEMM_CTRL_PERF_EN is defined.
module systolic_gemm_ctrl #(
  parameter int PE_ROWS      = 4,
  parameter int PE_COLS      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int K_W          = 8,
  parameter int PE_LAT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_gemm_ctrl_if.master  bus
);

  // Covers the far-corner PE's skew, its update latency and one cycle of margin.
  localparam int DRAIN_LEN = PE_ROWS + PE_COLS + PE_LAT + 1;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_len_q;
  logic [K_W-1:0]     k_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               start_ok;
  logic               flush;
  logic               rd_en;
  logic               rd_valid_q;

  assign start_ok = (state_q == IDLE) && bus.start;
  assign flush    = bus.abort && (state_q != IDLE);

  always_comb begin
    // NOTE: every combinational output gets its default first, so no path can infer a latch.
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = (bus.k_len == '0) ? DONE : CLEAR;
      CLEAR: state_d = FEED;
      FEED: begin
        if (!bus.feed_stall) begin
          rd_en = 1'b1;
          if (k_q == k_len_q - K_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      k_len_q    <= '0;
      k_q        <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_en;
      if (start_ok) k_len_q <= bus.k_len;
      if (start_ok || flush) k_q <= '0;
      else if (rd_en)        k_q <= k_q + K_W'(1);
      drain_q <= (state_q == DRAIN && state_d == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE) && !bus.abort;
  assign bus.clear_accum = (state_q == CLEAR);
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr     = k_q;

  // Lane r: one output register plus r skew registers; zeros ride along with valid=0.
  for (genvar r = 0; r < PE_ROWS; r++) begin : g_act
    logic [DATA_WIDTH-1:0] d_q [r+1];
    logic                  v_q [r+1];
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i <= r; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        v_q[0] <= rd_valid_q;
        d_q[0] <= rd_valid_q ? bus.act_rd_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int i = 1; i <= r; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end
    assign bus.act_out[r*DATA_WIDTH +: DATA_WIDTH] = d_q[r];
    assign bus.act_valid_out[r]                    = v_q[r];
  end

  for (genvar c = 0; c < PE_COLS; c++) begin : g_wgt
    logic [WEIGHT_WIDTH-1:0] d_q [c+1];
    logic                    v_q [c+1];
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i <= c; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        v_q[0] <= rd_valid_q;
        d_q[0] <= rd_valid_q ? bus.wgt_rd_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
        for (int i = 1; i <= c; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end
    assign bus.wgt_out[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = d_q[c];
    assign bus.wgt_valid_out[c]                        = v_q[c];
  end

`ifdef GEMM_CTRL_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else begin
      if (bus.busy && cycles_q != '1) cycles_q <= cycles_q + 32'd1;
      if (state_q == FEED && bus.feed_stall && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign bus.perf_cycles = cycles_q;
  assign bus.perf_stalls = stalls_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_stalls = '0;
`endif

endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// Self-checking bench for systolic_gemm_ctrl: per-job timeline model derived from
// read-issue cycles, directed scenarios followed by randomized jobs.
module tb_systolic_gemm_ctrl;
  localparam int PE_ROWS = 4;
  localparam int PE_COLS = 4;
  localparam int DW      = 16;
  localparam int WW      = 8;
  localparam int K_W     = 8;
  localparam int PE_LAT  = 1;
  localparam int D       = PE_ROWS + PE_COLS + PE_LAT + 1;
  localparam int MAXC    = 256;
  localparam int MAXK    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_gemm_ctrl_if #(
    .PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .K_W(K_W)
  ) bus ();

  systolic_gemm_ctrl #(
    .PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .K_W(K_W), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]  act_mem [MAXK][PE_ROWS];
  logic [WW-1:0]  wgt_mem [MAXK][PE_COLS];
  bit             stall_plan [MAXC];
  bit             exp_rd     [MAXC];
  int             exp_addr   [MAXC];
  bit             exp_av     [MAXC][PE_ROWS];
  logic [DW-1:0]  exp_ad     [MAXC][PE_ROWS];
  bit             exp_wv     [MAXC][PE_COLS];
  logic [WW-1:0]  exp_wd     [MAXC][PE_COLS];
  logic           prev_rd_en = 1'b0;
  logic [K_W-1:0] prev_addr  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int v);
`ifdef GEMM_CTRL_PERF_EN
    return 32'(v);
`else
    return 32'(v & 0);
`endif
  endfunction

  // One clock: drive inputs just after the edge, emulate the buffers, settle, sample.
  task automatic next_cycle(input bit st, input logic [K_W-1:0] kl, input bit ab,
                            input bit fs, input bit rs);
    @(posedge clk);
    #1;
    bus.start = st; bus.k_len = kl; bus.abort = ab; bus.feed_stall = fs; rst = rs;
    for (int r = 0; r < PE_ROWS; r++)
      bus.act_rd_data[r*DW +: DW] = (prev_rd_en && prev_addr < MAXK) ?
                                    act_mem[prev_addr][r] : DW'($urandom);
    for (int c = 0; c < PE_COLS; c++)
      bus.wgt_rd_data[c*WW +: WW] = (prev_rd_en && prev_addr < MAXK) ?
                                    wgt_mem[prev_addr][c] : WW'($urandom);
    #1;
    prev_rd_en = bus.rd_en;
    prev_addr  = bus.rd_addr;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"},     bus.busy, 0);
    check({tag, " done"},     bus.done, 0);
    check({tag, " rd_en"},    bus.rd_en, 0);
    check({tag, " rd_addr"},  bus.rd_addr, 0);
    check({tag, " clear"},    bus.clear_accum, 0);
    check({tag, " act_out"},  bus.act_out, 0);
    check({tag, " act_vld"},  bus.act_valid_out, 0);
    check({tag, " wgt_out"},  bus.wgt_out, 0);
    check({tag, " wgt_vld"},  bus.wgt_valid_out, 0);
    check({tag, " perf_cyc"}, bus.perf_cycles, 0);
    check({tag, " perf_stl"}, bus.perf_stalls, 0);
  endtask

  task automatic fill_mem(input bit pattern);
    for (int k = 0; k < MAXK; k++) begin
      for (int r = 0; r < PE_ROWS; r++) act_mem[k][r] = pattern ? DW'(16'h0100 * (k + 1)) : DW'($urandom);
      for (int c = 0; c < PE_COLS; c++) wgt_mem[k][c] = pattern ? WW'(8'h10 + k) : WW'($urandom);
    end
  endtask

  task automatic fill_stalls(input int pct);
    for (int i = 0; i < MAXC; i++) stall_plan[i] = (i < 150) && ($urandom_range(0, 99) < pct);
  endtask

  // Cycle 0 = start accepted. Reads fill FEED slots from cycle 2 skipping stalls; every
  // other expectation follows from the read-issue cycles.
  task automatic run_job(input int klen, input int abort_cyc, input int rst_cyc,
                         input int extra_start);
    int issue[$];
    int done_c, last_issue, last, t, n_st;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 0; exp_addr[i] = 0;
      for (int r = 0; r < PE_ROWS; r++) begin exp_av[i][r] = 0; exp_ad[i][r] = '0; end
      for (int c = 0; c < PE_COLS; c++) begin exp_wv[i][c] = 0; exp_wd[i][c] = '0; end
    end
    if (klen == 0) begin
      done_c = 1; last_issue = 0;
    end else begin
      t = 2;
      for (int k = 0; k < klen; k++) begin
        while (stall_plan[t]) t++;
        issue.push_back(t);
        t++;
      end
      last_issue = issue[klen-1];
      done_c     = last_issue + 1 + D;
      for (int k = 0; k < klen; k++) begin
        exp_rd[issue[k]] = 1; exp_addr[issue[k]] = k;
        for (int r = 0; r < PE_ROWS; r++) begin
          exp_av[issue[k]+2+r][r] = 1; exp_ad[issue[k]+2+r][r] = act_mem[k][r];
        end
        for (int c = 0; c < PE_COLS; c++) begin
          exp_wv[issue[k]+2+c][c] = 1; exp_wd[issue[k]+2+c][c] = wgt_mem[k][c];
        end
      end
    end
    last = (abort_cyc >= 0) ? abort_cyc : (rst_cyc >= 0) ? rst_cyc : done_c;

    for (int cy = 0; cy <= last; cy++) begin
      next_cycle(cy == 0 || cy == extra_start,
                 (cy == 0) ? K_W'(klen) : K_W'($urandom_range(1, 255)),
                 cy == abort_cyc, stall_plan[cy], cy == rst_cyc);
      check($sformatf("busy k%0d c%0d", klen, cy), bus.busy, (cy >= 1 && cy <= done_c));
      check($sformatf("done k%0d c%0d", klen, cy), bus.done, (cy == done_c));
      check($sformatf("clear k%0d c%0d", klen, cy), bus.clear_accum, (klen != 0 && cy == 1));
      if (cy != abort_cyc) begin
        check($sformatf("rd_en k%0d c%0d", klen, cy), bus.rd_en, exp_rd[cy]);
        if (exp_rd[cy])
          check($sformatf("rd_addr k%0d c%0d", klen, cy), bus.rd_addr, exp_addr[cy]);
      end
      for (int r = 0; r < PE_ROWS; r++) begin
        check($sformatf("act_vld[%0d] c%0d", r, cy), bus.act_valid_out[r], exp_av[cy][r]);
        check($sformatf("act_out[%0d] c%0d", r, cy), bus.act_out[r*DW +: DW], exp_ad[cy][r]);
      end
      for (int c = 0; c < PE_COLS; c++) begin
        check($sformatf("wgt_vld[%0d] c%0d", c, cy), bus.wgt_valid_out[c], exp_wv[cy][c]);
        check($sformatf("wgt_out[%0d] c%0d", c, cy), bus.wgt_out[c*WW +: WW], exp_wd[cy][c]);
      end
      if (cy >= 1) begin
        n_st = 0;
        for (int b = 2; b <= last_issue && b < cy; b++) n_st += stall_plan[b];
        check($sformatf("perf_cyc c%0d", cy), bus.perf_cycles,
              perf_exp((cy - 1 < done_c) ? cy - 1 : done_c));
        check($sformatf("perf_stl c%0d", cy), bus.perf_stalls, perf_exp(n_st));
      end
    end

    if (rst_cyc >= 0) begin
      next_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check_reset_values("mid_rst");
    end
  endtask

  initial begin
    int klen, ab, xs;
    bus.start = 1'b0; bus.k_len = '0; bus.abort = 1'b0; bus.feed_stall = 1'b0;
    bus.act_rd_data = '0; bus.wgt_rd_data = '0;
    fill_mem(1'b0);
    fill_stalls(0);

    repeat (3) next_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    next_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_reset_values("por");

    // Basic job with recognisable skew data: done in cycle 20.
    fill_mem(1'b1);
    run_job(8, -1, -1, -1);

    // Two stalls in cycles 3 and 4 of a K=4 job.
    fill_mem(1'b0);
    fill_stalls(0);
    stall_plan[3] = 1; stall_plan[4] = 1;
    run_job(4, -1, -1, -1);

    // Zero length, then a job with a start pulse while busy.
    fill_stalls(0);
    run_job(0, -1, -1, -1);
    run_job(5, -1, -1, 4);

    // Abort in cycle 5, new start in the very next cycle.
    run_job(8, 5, -1, -1);
    run_job(3, -1, -1, -1);

    // Reset during DRAIN, then a normal job.
    run_job(8, -1, 12, -1);
    run_job(2, -1, -1, -1);

    for (int j = 0; j < 24; j++) begin
      klen = $urandom_range(0, 20);
      fill_mem(1'b0);
      fill_stalls(30);
      ab = (klen > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, klen + 2) : -1;
      xs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, klen + 2) : -1;
      run_job(klen, ab, -1, xs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
